// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII transmit encoder.
package rgmii_pkg;

   localparam logic [1:0] SPEED_10   = 2'b00;
   localparam logic [1:0] SPEED_100  = 2'b01;
   localparam logic [1:0] SPEED_1000 = 2'b10;

   localparam logic PH_LO = 1'b0;
   localparam logic PH_HI = 1'b1;

   typedef struct packed {
      logic       en;
      logic       er;
      logic [7:0] d;
   } gmii_byte_t;

   // TXC operand pair {rise, fall} for a divider count within a period of d cycles
   function automatic logic [1:0] txc_pattern(input logic [31:0] cnt, input logic [31:0] d);
      logic [31:0] half;
      logic [1:0]  pat;
      half = d >> 1;
      pat  = 2'b00;
      if (cnt < half) begin
         pat = 2'b11;
      end else if (d[0] && (cnt == half)) begin
         pat = 2'b10;
      end
      return pat;
   endfunction

endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// Divider, nibble phase, TXC operand pattern and byte-accept strobe generation.
module rgmii_tx_clk_gen
   import rgmii_pkg::*;
#(
   parameter int unsigned DIV_100 = 5,
   parameter int unsigned DIV_10  = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed_i,
   input  logic       restart_i,
   output logic       count_wrap_c,
   output logic       phase_o,
   output logic       txc_1_o,
   output logic       txc_2_o,
   output logic       strobe_o
);

   localparam int unsigned DMAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
   localparam int unsigned CW   = $clog2(DMAX);

   logic [CW-1:0] count_q, count_d, last_c;
   logic [31:0]   div_c;
   logic          slow_c;
   logic          phase_d;
   logic [1:0]    txc_d;
   logic          strobe_d;

   // Outputs are computed from the next-state count so they line up with it.
   always_comb begin
      slow_c       = (speed_i == SPEED_10) || (speed_i == SPEED_100);
      div_c        = (speed_i == SPEED_100) ? 32'(DIV_100) : 32'(DIV_10);
      last_c       = (speed_i == SPEED_100) ? CW'(DIV_100 - 1) : CW'(DIV_10 - 1);
      count_wrap_c = slow_c && (count_q == last_c);
      count_d      = count_q;
      phase_d      = phase_o;
      if (restart_i || !slow_c) begin
         count_d = '0;
         phase_d = PH_LO;
      end else if (count_wrap_c) begin
         count_d = '0;
         phase_d = ~phase_o;
      end else begin
         count_d = count_q + 1'b1;
      end
      txc_d    = slow_c ? txc_pattern(32'(count_d), div_c) : 2'b10;
      strobe_d = !restart_i && (!slow_c || ((count_d == last_c) && (phase_d == PH_HI)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         phase_o  <= PH_LO;
         txc_1_o  <= 1'b0;
         txc_2_o  <= 1'b0;
         strobe_o <= 1'b0;
      end else begin
         count_q  <= count_d;
         phase_o  <= phase_d;
         txc_1_o  <= txc_d[1];
         txc_2_o  <= txc_d[0];
         strobe_o <= strobe_d;
      end
   end

endmodule

// File: rtl/rgmii_tx_encoder.sv
// GMII to RGMII DDR-operand encoder for 1000/100/10 Mb/s from one 125 MHz clock.
// Define RGMII_TX_ER_EN to carry gmii_tx_er onto the falling TX_CTL operand.
module rgmii_tx_encoder
   import rgmii_pkg::*;
#(
   parameter int unsigned DIV_100 = 5,
   parameter int unsigned DIV_10  = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic [7:0] gmii_txd,
   input  logic       gmii_tx_en,
   input  logic       gmii_tx_er,
   output logic       gmii_tx_clk_en,
   output logic [3:0] rgmii_txd_1,
   output logic [3:0] rgmii_txd_2,
   output logic       rgmii_tx_ctl_1,
   output logic       rgmii_tx_ctl_2,
   output logic       rgmii_txc_1,
   output logic       rgmii_txc_2
);

`ifdef RGMII_TX_ER_EN
   localparam logic ER_EN = 1'b1;
`else
   localparam logic ER_EN = 1'b0;
`endif

   logic [1:0] speed_q;
   gmii_byte_t byte_q, byte_d, in_byte_c;
   logic [3:0] txd_1_d, txd_2_d;
   logic       ctl_1_d, ctl_2_d;
   logic       restart_c, count_wrap_c, phase;

   rgmii_tx_clk_gen #(
      .DIV_100 (DIV_100),
      .DIV_10  (DIV_10)
   ) u_clk_gen (
      .clk          (clk),
      .rst          (rst),
      .speed_i      (speed),
      .restart_i    (restart_c),
      .count_wrap_c (count_wrap_c),
      .phase_o      (phase),
      .txc_1_o      (rgmii_txc_1),
      .txc_2_o      (rgmii_txc_2),
      .strobe_o     (gmii_tx_clk_en)
   );

   // Capture on strobe; the high nibble follows at the next divider wrap.
   always_comb begin
      restart_c = (speed != speed_q);
      in_byte_c = '{en: gmii_tx_en, er: gmii_tx_er, d: gmii_txd};
      byte_d    = byte_q;
      txd_1_d   = rgmii_txd_1;
      txd_2_d   = rgmii_txd_2;
      ctl_1_d   = rgmii_tx_ctl_1;
      ctl_2_d   = rgmii_tx_ctl_2;
      if (restart_c) begin
         byte_d  = '0;
         txd_1_d = 4'h0;
         txd_2_d = 4'h0;
         ctl_1_d = 1'b0;
         ctl_2_d = 1'b0;
      end else if (gmii_tx_clk_en) begin
         byte_d  = in_byte_c;
         txd_1_d = gmii_txd[3:0];
         txd_2_d = (speed_q == SPEED_10 || speed_q == SPEED_100) ? gmii_txd[3:0] : gmii_txd[7:4];
         ctl_1_d = gmii_tx_en;
         ctl_2_d = gmii_tx_en ^ (gmii_tx_er & ER_EN);
      end else if (count_wrap_c && (phase == PH_LO)) begin
         txd_1_d = byte_q.d[7:4];
         txd_2_d = byte_q.d[7:4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         speed_q        <= speed;
         byte_q         <= '0;
         rgmii_txd_1    <= 4'h0;
         rgmii_txd_2    <= 4'h0;
         rgmii_tx_ctl_1 <= 1'b0;
         rgmii_tx_ctl_2 <= 1'b0;
      end else begin
         speed_q        <= speed;
         byte_q         <= byte_d;
         rgmii_txd_1    <= txd_1_d;
         rgmii_txd_2    <= txd_2_d;
         rgmii_tx_ctl_1 <= ctl_1_d;
         rgmii_tx_ctl_2 <= ctl_2_d;
      end
   end

endmodule

// File: tb/tb_rgmii_tx_encoder.sv
// Directed self-checking bench for rgmii_tx_encoder (default DIV_100=5, DIV_10=50).
module tb_rgmii_tx_encoder;

`ifdef RGMII_TX_ER_EN
   localparam logic ER_ON = 1'b1;
`else
   localparam logic ER_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] speed;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en, gmii_tx_er;
   logic       gmii_tx_clk_en;
   logic [3:0] rgmii_txd_1, rgmii_txd_2;
   logic       rgmii_tx_ctl_1, rgmii_tx_ctl_2, rgmii_txc_1, rgmii_txc_2;

   int n_vec = 0;
   int n_bad = 0;

   rgmii_tx_encoder dut (
      .clk            (clk),
      .rst            (rst),
      .speed          (speed),
      .gmii_txd       (gmii_txd),
      .gmii_tx_en     (gmii_tx_en),
      .gmii_tx_er     (gmii_tx_er),
      .gmii_tx_clk_en (gmii_tx_clk_en),
      .rgmii_txd_1    (rgmii_txd_1),
      .rgmii_txd_2    (rgmii_txd_2),
      .rgmii_tx_ctl_1 (rgmii_tx_ctl_1),
      .rgmii_tx_ctl_2 (rgmii_tx_ctl_2),
      .rgmii_txc_1    (rgmii_txc_1),
      .rgmii_txc_2    (rgmii_txc_2)
   );

   always #4 clk = ~clk;

   // Advance one rising edge and settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [14:0] obs;
      rst = 1'b1; speed = 2'b10; gmii_txd = 8'h00; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
      step(); step();
      obs = {gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2,
             rgmii_txc_1, rgmii_txc_2, 2'b00};
      n_vec++;
      if (obs !== 15'h0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, 15'h0);
      end
      rst = 1'b0;
      step();
      n_vec++;
      if ({gmii_tx_clk_en, rgmii_txc_1, rgmii_txc_2, rgmii_txd_1} !== 7'b1_10_0000) begin
         n_bad++; $display("FAIL post_reset_1g: got %b want 1100000",
                           {gmii_tx_clk_en, rgmii_txc_1, rgmii_txc_2, rgmii_txd_1});
      end
   endtask

   task automatic test_1000();
      logic [7:0] bytes [2];
      logic [7:0] exp  [2];
      bytes[0] = 8'hA5; exp[0] = 8'h5A;
      bytes[1] = 8'h3C; exp[1] = 8'hC3;
      for (int i = 0; i < 2; i++) begin
         gmii_txd = bytes[i]; gmii_tx_en = 1'b1; gmii_tx_er = 1'b0;
         step();
         n_vec++;
         if ({rgmii_txd_1, rgmii_txd_2} !== exp[i]) begin
            n_bad++; $display("FAIL g1_txd[%0d]: got %h want %h", i, {rgmii_txd_1, rgmii_txd_2}, exp[i]);
         end
         n_vec++;
         if ({gmii_tx_clk_en, rgmii_tx_ctl_1, rgmii_tx_ctl_2, rgmii_txc_1, rgmii_txc_2} !== 5'b1_11_10) begin
            n_bad++; $display("FAIL g1_ctl_txc[%0d]: got %b want 11110", i,
                              {gmii_tx_clk_en, rgmii_tx_ctl_1, rgmii_tx_ctl_2, rgmii_txc_1, rgmii_txc_2});
         end
      end
   endtask

   task automatic test_tx_er();
      gmii_txd = 8'h00; gmii_tx_en = 1'b1; gmii_tx_er = 1'b1;
      step();
      n_vec++;
      if ({rgmii_tx_ctl_1, rgmii_tx_ctl_2} !== {1'b1, ~ER_ON}) begin
         n_bad++; $display("FAIL tx_er_ctl: got %b want %b", {rgmii_tx_ctl_1, rgmii_tx_ctl_2}, {1'b1, ~ER_ON});
      end
      gmii_tx_er = 1'b0;
   endtask

   // 1000 -> 100 switch mid-stream, then one 0x96 byte at 100 Mb/s
   task automatic test_100();
      logic [1:0] txc_exp [5];
      int         edges;
      txc_exp[0] = 2'b11; txc_exp[1] = 2'b11; txc_exp[2] = 2'b10; txc_exp[3] = 2'b00; txc_exp[4] = 2'b00;
      speed = 2'b01; gmii_txd = 8'h96; gmii_tx_en = 1'b1;
      step();
      n_vec++;
      if ({gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2} !== 11'h0) begin
         n_bad++; $display("FAIL switch_idle: got %h want 000",
                           {gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2});
      end
      edges = 0;
      while (gmii_tx_clk_en !== 1'b1 && edges < 20) begin
         step();
         edges++;
      end
      n_vec++;
      if (edges !== 9) begin
         n_bad++; $display("FAIL first_strobe_delay: got %0d edges want 9", edges);
      end
      for (int k = 0; k < 10; k++) begin
         step();
         n_vec++;
         if ({rgmii_txd_1, rgmii_txd_2} !== ((k < 5) ? 8'h66 : 8'h99)) begin
            n_bad++; $display("FAIL m100_txd[%0d]: got %h want %h", k, {rgmii_txd_1, rgmii_txd_2},
                              (k < 5) ? 8'h66 : 8'h99);
         end
         n_vec++;
         if ({rgmii_txc_1, rgmii_txc_2} !== txc_exp[k % 5]) begin
            n_bad++; $display("FAIL m100_txc[%0d]: got %b want %b", k, {rgmii_txc_1, rgmii_txc_2}, txc_exp[k % 5]);
         end
         n_vec++;
         if ({gmii_tx_clk_en, rgmii_tx_ctl_1, rgmii_tx_ctl_2} !== {(k == 9), 2'b11}) begin
            n_bad++; $display("FAIL m100_strobe_ctl[%0d]: got %b want %b", k,
                              {gmii_tx_clk_en, rgmii_tx_ctl_1, rgmii_tx_ctl_2}, {(k == 9), 2'b11});
         end
      end
   endtask

   // Reset pulse inside a 100 Mb/s high-nibble period
   task automatic test_rst_mid();
      gmii_txd = 8'h5A; gmii_tx_en = 1'b1;
      step();
      n_vec++;
      if ({rgmii_txd_1, rgmii_txd_2} !== 8'hAA) begin
         n_bad++; $display("FAIL rmid_lo: got %h want aa", {rgmii_txd_1, rgmii_txd_2});
      end
      repeat (5) step();
      n_vec++;
      if ({rgmii_txd_1, rgmii_txd_2} !== 8'h55) begin
         n_bad++; $display("FAIL rmid_hi: got %h want 55", {rgmii_txd_1, rgmii_txd_2});
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++;
      if ({gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2,
           rgmii_txc_1, rgmii_txc_2} !== 13'h0) begin
         n_bad++; $display("FAIL rmid_zero: got %h want 0000",
                           {gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2,
                            rgmii_txc_1, rgmii_txc_2});
      end
      for (int i = 1; i <= 9; i++) begin
         step();
         n_vec++;
         if ({gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2} !=
             {(i == 9), 10'h0}) begin
            n_bad++; $display("FAIL rmid_idle[%0d]: got %h want %h", i,
                              {gmii_tx_clk_en, rgmii_txd_1, rgmii_txd_2, rgmii_tx_ctl_1, rgmii_tx_ctl_2},
                              {(i == 9), 10'h0});
         end
      end
   endtask

   // 10 Mb/s: 50-cycle TXC period, strobe every 100 cycles, nibbles move only at count 0
   task automatic test_10();
      logic [7:0] prev;
      int         c, ph;
      logic [1:0] txc_w;
      speed = 2'b00; gmii_txd = 8'h3C; gmii_tx_en = 1'b1;
      prev = 8'h00;
      for (int i = 0; i < 200; i++) begin
         step();
         c  = i % 50;
         ph = (i / 50) % 2;
         txc_w = (c < 25) ? 2'b11 : 2'b00;
         n_vec++;
         if ({rgmii_txc_1, rgmii_txc_2} !== txc_w) begin
            n_bad++; $display("FAIL m10_txc[%0d]: got %b want %b", i, {rgmii_txc_1, rgmii_txc_2}, txc_w);
         end
         n_vec++;
         if (gmii_tx_clk_en !== ((c == 49) && (ph == 1))) begin
            n_bad++; $display("FAIL m10_strobe[%0d]: got %b want %b", i, gmii_tx_clk_en, (c == 49) && (ph == 1));
         end
         if (c != 0) begin
            n_vec++;
            if ({rgmii_txd_1, rgmii_txd_2} !== prev) begin
               n_bad++; $display("FAIL m10_stable[%0d]: got %h want %h", i, {rgmii_txd_1, rgmii_txd_2}, prev);
            end
         end
         if (i == 100 || i == 150) begin
            n_vec++;
            if ({rgmii_txd_1, rgmii_txd_2} !== ((i == 100) ? 8'hCC : 8'h33)) begin
               n_bad++; $display("FAIL m10_nibble[%0d]: got %h want %h", i, {rgmii_txd_1, rgmii_txd_2},
                                 (i == 100) ? 8'hCC : 8'h33);
            end
         end
         prev = {rgmii_txd_1, rgmii_txd_2};
      end
   endtask

   initial begin
      test_reset();
      test_1000();
      test_tx_er();
      test_100();
      test_rst_mid();
      test_10();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
